// File: rtl/and4_pkg.sv
// Shared definitions for the and4 arbiter: state encoding, default widths
// and the rotating-priority pick used by round-robin arbiters.
package and4_pkg;

    localparam int AND_W = 4;
    localparam int N_REQ = 4;
    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Returns the first set bit of req at or above ptr, wrapping at n-1;
    // callers only use the result when req has at least one bit set.
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/and4.sv
// Shared bitwise-AND datapath; a single combinational stage.
module and4
    import and4_pkg::*;
#(
    parameter int W = AND_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/and4_arbiter.sv
// Round-robin arbiter that time-shares one and4 datapath between N requesters,
// returning each registered result tagged with its requester index.
module and4_arbiter
    import and4_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = AND_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       a_flat,
    input  logic [N*W-1:0]       b_flat,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_y
);

    localparam int IW = $clog2(N);

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     id_q;
    logic [IW-1:0]     winner;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      and_y;
    logic [MAX_N-1:0]  req_ext;

    and4 #(.W(W)) u_and4 (
        .a (a_q),
        .b (b_q),
        .y (and_y)
    );

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        winner         = IW'(rr_pick(req_ext, int'(ptr), N));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = EXEC;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == EXEC);

    // Requests are ignored while EXEC so operands are only ever sampled
    // at the IDLE capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        a_q  <= a_flat[winner*W +: W];
                        b_q  <= b_flat[winner*W +: W];
                        gnt  <= {{(N-1){1'b0}}, 1'b1} << winner;
                        id_q <= winner;
                        ptr  <= (winner == IW'(N-1)) ? '0 : winner + IW'(1);
                    end
                end
                EXEC: begin
                    rsp_y     <= and_y;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    gnt       <= '0;
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_and4_arbiter.sv
// Self-checking bench for and4_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_and4_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]  gnt;
    logic          busy;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_y;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    and4_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (((r >> idx) & 4'b1) != 4'b0) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        step; step;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        step; step;
        n_checks++;
        if ({gnt, busy, rsp_valid, rsp_id, rsp_y} !== 12'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b expected 0", {gnt, busy, rsp_valid, rsp_id, rsp_y});
        end
        rst = 1'b0;
        step;
        n_checks++;
        if ({gnt, busy, rsp_valid} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %b expected 0", {gnt, busy, rsp_valid});
        end
        m_ptr = 0;
    endtask

    task automatic test_single;
        req = 4'b0001; a_flat[3:0] = 4'b1010; b_flat[3:0] = 4'b1111;
        step;
        n_checks++;
        if ({gnt, busy} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL single_gnt: got gnt=%b busy=%b expected 0001/1", gnt, busy);
        end
        req = '0;
        step;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_y, gnt, busy} !== {1'b1, 2'd0, 4'b1010, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_rsp: got v=%b id=%0d y=%b gnt=%b busy=%b expected 1/0/1010/0000/0",
                     rsp_valid, rsp_id, rsp_y, gnt, busy);
        end
        step;
        n_checks++;
        if ({rsp_valid, rsp_y} !== {1'b0, 4'b1010}) begin
            n_fail++;
            $display("[TB] FAIL single_hold: got v=%b y=%b expected 0/1010", rsp_valid, rsp_y);
        end
        m_ptr = 1;
    endtask

    task automatic test_all_four;
        int          exp_id [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_y  [5] = '{4'b0000, 4'b0000, 4'b1010, 4'b0100, 4'b0000};
        do_reset;
        a_flat = {4'b1100, 4'b1111, 4'b1010, 4'b0000};
        b_flat = {4'b0110, 4'b1010, 4'b0101, 4'b0000};
        req = 4'b1111;
        for (int op = 0; op < 5; op++) begin
            step;
            n_checks++;
            if ({gnt, busy} !== {4'b0001 << exp_id[op], 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL all4_gnt[%0d]: got gnt=%b busy=%b expected id %0d", op, gnt, busy, exp_id[op]);
            end
            step;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'(exp_id[op]), exp_y[op]}) begin
                n_fail++;
                $display("[TB] FAIL all4_rsp[%0d]: got v=%b id=%0d y=%b expected 1/%0d/%b",
                         op, rsp_valid, rsp_id, rsp_y, exp_id[op], exp_y[op]);
            end
        end
        req = '0;
        m_ptr = 1;
    endtask

    task automatic test_fairness;
        do_reset;
        req = 4'b0010;
        step; req = '0; step;
        n_checks++;
        if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL fair_first: got v=%b id=%0d expected 1/1", rsp_valid, rsp_id);
        end
        req = 4'b0011;
        step;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL fair_wrap: got gnt=%b expected 0001", gnt);
        end
        step;
        step;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL fair_next: got gnt=%b expected 0010", gnt);
        end
        req = '0;
        step;
        m_ptr = 2;
    endtask

    task automatic test_operand_change;
        do_reset;
        req = 4'b0100; a_flat[11:8] = 4'b1111; b_flat[11:8] = 4'b1010;
        step;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL opchg_gnt: got gnt=%b expected 0100", gnt);
        end
        a_flat = '0; b_flat = '0; req = '0;
        step;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd2, 4'b1010}) begin
            n_fail++;
            $display("[TB] FAIL opchg_rsp: got v=%b id=%0d y=%b expected 1/2/1010", rsp_valid, rsp_id, rsp_y);
        end
        m_ptr = 3;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req = 4'b0010;
        step;
        req = '0; rst = 1'b1;
        step;
        n_checks++;
        if ({gnt, busy, rsp_valid} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_abort: got gnt=%b busy=%b v=%b expected 0", gnt, busy, rsp_valid);
        end
        rst = 1'b0;
        step;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_novalid: got v=%b expected 0", rsp_valid);
        end
        req = 4'b1001;
        step;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL midrst_ptr: got gnt=%b expected 0001", gnt);
        end
        req = '0;
        step;
        req = 4'b1000;
        step;
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL midrst_r3: got gnt=%b expected 1000", gnt);
        end
        req = '0;
        step;
        m_ptr = 0;
    endtask

    task automatic test_random;
        logic [N-1:0]   r;
        logic [N*W-1:0] a, b;
        logic [W-1:0]   exp_y;
        logic [W-1:0]   last_y;
        int             w;
        do_reset;
        last_y = '0;
        for (int it = 0; it < 60; it++) begin
            r = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            req = r; a_flat = a; b_flat = b;
            step;
            if (r == '0) begin
                n_checks++;
                if ({gnt, busy, rsp_valid, rsp_y} !== {4'b0, 1'b0, 1'b0, last_y}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_idle[%0d]: got gnt=%b busy=%b v=%b y=%b expected 0/0/0/%b",
                             it, gnt, busy, rsp_valid, rsp_y, last_y);
                end
            end else begin
                w = model_pick(r, m_ptr);
                m_ptr = (w + 1) % N;
                exp_y = a[w*W +: W] & b[w*W +: W];
                n_checks++;
                if ({gnt, busy} !== {4'b0001 << w, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_gnt[%0d]: got gnt=%b busy=%b expected id %0d", it, gnt, busy, w);
                end
                req = 4'($urandom_range(0, 15));
                a_flat = 16'($urandom);
                b_flat = 16'($urandom);
                step;
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_y, gnt} !== {1'b1, 2'(w), exp_y, 4'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_rsp[%0d]: got v=%b id=%0d y=%b gnt=%b expected 1/%0d/%b/0000",
                             it, rsp_valid, rsp_id, rsp_y, gnt, w, exp_y);
                end
                last_y = exp_y;
            end
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        test_reset;
        test_single;
        test_all_four;
        test_fairness;
        test_operand_change;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
